// File: rtl/ram_single_port_pkg.sv
// ----------------------------------------------------------------------------
// ram_single_port_pkg
//
// Shared defaults and word/address types for the single-port flop RAM.
// The top module and its storage array take these as parameter defaults.
// Benches and neighbouring blocks can also use word_t / addr_t directly.
// ----------------------------------------------------------------------------
package ram_single_port_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 6;
  localparam int unsigned DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

  typedef logic [DATA_WIDTH_DEF-1:0] word_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

endpackage : ram_single_port_pkg

// File: rtl/ram_single_port_array.sv
// ----------------------------------------------------------------------------
// ram_single_port_array
//
// Flop-based storage for ram_single_port. It provides:
//   - DEPTH words of DATA_WIDTH bits, all cleared by the asynchronous reset;
//   - a one-hot write decode driven from the write address and enable;
//   - a purely combinational read mux.
// The read mux returns the value held before the current edge. A write at
// that edge is not visible through rd_data_o until after the edge.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset, clears every word
//   we_i       in   write enable, active high
//   wr_addr_i  in   write address  [ADDR_WIDTH]
//   wr_data_i  in   write data     [DATA_WIDTH]
//   rd_addr_i  in   read address   [ADDR_WIDTH]
//   rd_data_o  out  combinational read data [DATA_WIDTH]
// ----------------------------------------------------------------------------
module ram_single_port_array
  import ram_single_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      wr_en;

  // One-hot write decode. Every address value is in range, so there is no
  // guard on the index.
  always_comb begin
    // NOTE: assign a default before any conditional assignment in a
    // combinational block. Without it, the unassigned paths infer a latch.
    wr_en = '0;
    if (we_i) begin
      wr_en[wr_addr_i] = 1'b1;
    end
  end

  // NOTE: this is a flop array rather than an inferred RAM macro. Clearing it
  // in the reset branch is therefore legal, and it is the only way contents
  // read deterministically after reset. An SRAM macro cannot be reset like
  // this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          // NOTE: sequential state uses non-blocking assignment. Readers in
          // the same time step then see the pre-edge value, which is what
          // gives read-before-write.
          mem_q[i] <= wr_data_i;
        end
      end
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : ram_single_port_array

// File: rtl/ram_single_port.sv
// ----------------------------------------------------------------------------
// ram_single_port
//
// Synchronous DEPTH x DATA_WIDTH RAM with one clock, one write port and one
// read port, using independent addresses. Behaviour:
//   - Writes occur on the rising edge when we = 1.
//   - Read data is registered: the address presented before edge N appears
//     on q after edge N. q holds its value between edges.
//   - The asynchronous reset clears q and every stored word immediately.
//
// Read-during-write to the same address:
//   - Default build: read-before-write. q gets the old word.
//   - With `define RAM_SP_WRITE_FIRST_EN: write-first. q gets data, which is
//     bypassed around the array.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   q           out  registered read data [DATA_WIDTH]
//   data        in   write data            [DATA_WIDTH]
//   read_addr   in   read address          [ADDR_WIDTH]
//   write_addr  in   write address         [ADDR_WIDTH]
//   we          in   write enable, active high
// ----------------------------------------------------------------------------
module ram_single_port
  import ram_single_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] q,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  we
);

  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] q_d;
  logic [DATA_WIDTH-1:0] q_q;

  ram_single_port_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we),
    .wr_addr_i (write_addr),
    .wr_data_i (data),
    .rd_addr_i (read_addr),
    .rd_data_o (rd_word)
  );

`ifdef RAM_SP_WRITE_FIRST_EN
  // Write-first: a same-address write bypasses the array, so q sees the new
  // word at the same edge that stores it.
  logic collision;
  assign collision = we && (write_addr == read_addr);

  always_comb begin
    q_d = rd_word;
    if (collision) begin
      q_d = data;
    end
  end
`else
  // Read-before-write: the array mux still shows the pre-edge contents, so
  // registering it directly returns the old word on a collision.
  assign q_d = rd_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : ram_single_port

// File: tb/tb_ram_single_port.sv
// ----------------------------------------------------------------------------
// tb_ram_single_port
//
// Directed bench for ram_single_port. It covers:
//   - reset state, including reset asserted mid-cycle;
//   - basic write/read and read latency;
//   - same-address collision in either build;
//   - independent read and write ports;
//   - we held low;
//   - reset asserted coincident with a write.
// Inputs change and q is sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_ram_single_port;
  import ram_single_port_pkg::*;

  logic  clk;
  logic  rst_n;
  word_t q;
  word_t data;
  addr_t read_addr;
  addr_t write_addr;
  logic  we;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef RAM_SP_WRITE_FIRST_EN
  localparam word_t COLLIDE_EXP = 8'hF0;
`else
  localparam word_t COLLIDE_EXP = 8'hAA;
`endif

  ram_single_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q          (q),
    .data       (data),
    .read_addr  (read_addr),
    .write_addr (write_addr),
    .we         (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, take one rising edge, settle past it.
  task automatic cyc(input logic w, input addr_t wa, input word_t d, input addr_t ra);
    we         = w;
    write_addr = wa;
    data       = d;
    read_addr  = ra;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    we         = 1'b0;
    data       = '0;
    read_addr  = '0;
    write_addr = '0;

    // Reset state
    #3;
    check("reset_q", q, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 6'd0, 8'h00, 6'd0);
    check("rst_rd0", q, 8'h00);
    cyc(1'b0, 6'd0, 8'h00, 6'd5);
    check("rst_rd5", q, 8'h00);
    cyc(1'b0, 6'd0, 8'h00, 6'd63);
    check("rst_rd63", q, 8'h00);

    // Basic write/read
    cyc(1'b1, 6'd5, 8'hAA, 6'd0);
    check("wr5_rd0", q, 8'h00);
    cyc(1'b1, 6'd10, 8'hB3, 6'd0);
    cyc(1'b0, 6'd0, 8'h00, 6'd16);
    check("rd16", q, 8'h00);
    cyc(1'b0, 6'd0, 8'h00, 6'd10);
    check("rd10", q, 8'hB3);
    cyc(1'b0, 6'd0, 8'h00, 6'd5);
    check("rd5", q, 8'hAA);
    // q holds between edges
    #4;
    check("hold", q, 8'hAA);
    @(negedge clk);
    #1;
    check("hold2", q, 8'hAA);
    @(posedge clk);
    #1;

    // Same-address collision
    cyc(1'b1, 6'd5, 8'hF0, 6'd5);
    check("collide", q, COLLIDE_EXP);
    cyc(1'b0, 6'd5, 8'hF0, 6'd5);
    check("collide_next", q, 8'hF0);

    // Independent ports
    cyc(1'b1, 6'd0, 8'h11, 6'd63);
    cyc(1'b1, 6'd63, 8'h3C, 6'd0);
    check("indep_rd0", q, 8'h11);
    cyc(1'b0, 6'd0, 8'h00, 6'd63);
    check("indep_rd63", q, 8'h3C);

    // we low leaves memory unchanged
    cyc(1'b0, 6'd10, 8'hFF, 6'd10);
    check("we0_same", q, 8'hB3);
    cyc(1'b0, 6'd0, 8'h00, 6'd10);
    check("we0_after", q, 8'hB3);

    // Asynchronous reset mid-cycle: q clears without waiting for an edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_q", q, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 6'd0, 8'h00, 6'd10);
    check("async_rd10", q, 8'h00);

    // Reset coincident with a write to address 7
    cyc(1'b1, 6'd20, 8'h5A, 6'd0);
    cyc(1'b1, 6'd7, 8'h77, 6'd0);
    cyc(1'b1, 6'd63, 8'hC3, 6'd20);
    check("pre_rd20", q, 8'h5A);
    we         = 1'b1;
    write_addr = 6'd7;
    data       = 8'hEE;
    read_addr  = 6'd7;
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_q", q, 8'h00);
    we    = 1'b0;
    rst_n = 1'b1;
    cyc(1'b0, 6'd0, 8'h00, 6'd7);
    check("midrst_rd7", q, 8'h00);
    cyc(1'b0, 6'd0, 8'h00, 6'd20);
    check("midrst_rd20", q, 8'h00);
    cyc(1'b0, 6'd0, 8'h00, 6'd63);
    check("midrst_rd63", q, 8'h00);

    // Normal operation resumes after the reset release
    cyc(1'b1, 6'd7, 8'h42, 6'd0);
    cyc(1'b0, 6'd0, 8'h00, 6'd7);
    check("post_rd7", q, 8'h42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ram_single_port
